// File: rtl/noc_input_unit.sv
// NoC router input unit: flit FIFO with XY route computation and packet tracking.
// Optional same-cycle bypass of an empty queue: define NOC_INPUT_BYPASS_EN.
package noc_pkg;

  typedef struct packed {
    logic [2:0] y;
    logic [2:0] x;
  } xy_t;

  typedef struct packed {
    logic head;
    logic tail;
  } preamble_t;

  typedef enum logic [4:0] {
    goNone  = 5'b00000,
    goNorth = 5'b00001,
    goEast  = 5'b00010,
    goSouth = 5'b00100,
    goWest  = 5'b01000,
    goLocal = 5'b10000
  } direction_t;

endpackage

module noc_input_unit
  import noc_pkg::*;
#(
  parameter int DataWidth      = 64,
  parameter int PortQueueDepth = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  xy_t                  position,
  input  logic [DataWidth-1:0] data_in,
  input  logic                 data_in_valid,
  output logic                 data_in_ready,
  output logic [DataWidth-1:0] data_out,
  output logic                 data_out_valid,
  input  logic                 data_out_ready,
  output direction_t           route_out,
  output logic                 protocol_err
);

  localparam int PtrW = $clog2(PortQueueDepth);
  localparam int CntW = PtrW + 1;
  localparam logic [CntW-1:0] Full = CntW'(PortQueueDepth);

  typedef enum logic {
    IDLE,
    PACKET
  } state_t;

  logic [DataWidth-1:0] mem [PortQueueDepth];
  logic [PtrW-1:0]      rd_ptr;
  logic [PtrW-1:0]      wr_ptr;
  logic [CntW-1:0]      count;
  logic                 active_q;

  state_t     state_q;
  state_t     state_d;
  direction_t route_reg;
  direction_t route_d;
  direction_t xy_route;

  logic [DataWidth-1:0] out_flit;
  preamble_t            pre;
  xy_t                  dst;
  logic                 empty;
  logic                 have_flit;
  logic                 bypass;
  logic                 drop;
  logic                 fire;
  logic                 enq;
  logic                 deq;

  assign empty         = (count == '0);
  assign data_in_ready = active_q && (count != Full);

`ifdef NOC_INPUT_BYPASS_EN
  // An empty queue lets a routable flit straight through to a granted switch.
  assign bypass = empty && data_in_valid && data_in_ready
                  && data_out_ready
                  && ((state_q == PACKET) || data_in[DataWidth-1]);
  assign out_flit  = bypass ? data_in : mem[rd_ptr];
  assign have_flit = !empty || bypass;
`else
  assign bypass    = 1'b0;
  assign out_flit  = mem[rd_ptr];
  assign have_flit = !empty;
`endif

  assign pre = preamble_t'(out_flit[DataWidth-1:DataWidth-2]);
  assign dst = xy_t'(out_flit[DataWidth-9:DataWidth-14]);

  always_comb begin
    xy_route = goLocal;
    if (dst.x > position.x)      xy_route = goEast;
    else if (dst.x < position.x) xy_route = goWest;
    else if (dst.y > position.y) xy_route = goSouth;
    else if (dst.y < position.y) xy_route = goNorth;
  end

  // A body/tail flit with no open packet is an orphan and is discarded.
  assign drop = !empty && !bypass
                && (state_q == IDLE) && !pre.head;

  assign data_out_valid = have_flit && !drop;
  assign data_out       = out_flit;

  always_comb begin
    route_out = goNone;
    if (data_out_valid) begin
      route_out = (state_q == PACKET) ? route_reg : xy_route;
    end
  end

  assign fire = data_out_valid && data_out_ready;
  assign deq  = (fire && !bypass) || drop;
  assign enq  = data_in_valid && data_in_ready && !bypass;

  always_comb begin
    state_d = state_q;
    route_d = route_reg;
    if (fire) begin
      unique case (state_q)
        IDLE: begin
          if (pre.head && !pre.tail) begin
            state_d = PACKET;
            route_d = xy_route;
          end
        end
        PACKET: begin
          if (pre.tail) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      route_reg <= goNone;
    end else begin
      state_q   <= state_d;
      route_reg <= route_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      active_q     <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      active_q <= 1'b1;
      if (enq) wr_ptr <= wr_ptr + PtrW'(1);
      if (deq) rd_ptr <= rd_ptr + PtrW'(1);
      unique case ({enq, deq})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
      if (drop) protocol_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= data_in;
  end

endmodule

// File: tb/tb_noc_input_unit.sv
// Scoreboard bench for noc_input_unit: directed flits, decoupled output monitor.
module tb_noc_input_unit;
  import noc_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  xy_t         position;
  logic [63:0] data_in = '0;
  logic        data_in_valid = 1'b0;
  logic        data_in_ready;
  logic [63:0] data_out;
  logic        data_out_valid;
  logic        data_out_ready = 1'b0;
  direction_t  route_out;
  logic        protocol_err;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    logic [63:0] d;
    logic [4:0]  r;
  } exp_t;
  exp_t sb[$];

  noc_input_unit #(
    .DataWidth(64),
    .PortQueueDepth(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .position(position),
    .data_in(data_in),
    .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready),
    .data_out(data_out),
    .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready),
    .route_out(route_out),
    .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] a,
                     input logic [63:0] e);
    total_cnt++;
    if (a === e) pass_cnt++;
    else $display("FAIL %s: got %h want %h", n, a, e);
  endtask

  function automatic logic [63:0] mk(input bit h, input bit t,
                                     input int dx, input int dy,
                                     input logic [49:0] pl);
    logic [63:0] f;
    f = '0;
    f[63] = h;
    f[62] = t;
    f[55:53] = dy[2:0];
    f[52:50] = dx[2:0];
    f[49:0] = pl;
    return f;
  endfunction

  always @(negedge clk) begin
    if (rst && data_out_valid && data_out_ready) begin
      if (sb.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_out: got data=%h route=%b want none",
                 data_out, route_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_data", data_out, e.d);
        chk("out_route", 64'(route_out), 64'(e.r));
      end
    end
  end

  task automatic push(input logic [63:0] f, input logic [4:0] r,
                      input bit scored);
    bit rdy;
    bit done;
    exp_t e;
    done = 1'b0;
    if (scored) begin
      e.d = f;
      e.r = r;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    data_in = f;
    data_in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      rdy = data_in_ready;
      @(posedge clk);
      if (rdy) begin
        done = 1'b1;
        break;
      end
    end
    #1;
    data_in_valid = 1'b0;
    if (!done) begin
      total_cnt++;
      $display("FAIL push_timeout: got no accept want accept of %h", f);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  task automatic pulse_rst();
    @(posedge clk);
    #1;
    rst = 1'b0;
    data_in_valid = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    position.x = 3'd2;
    position.y = 3'd2;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(data_in_ready), 64'd0);
    chk("rst_out_valid", 64'(data_out_valid), 64'd0);
    chk("rst_route", 64'(route_out), 64'd0);
    chk("rst_err", 64'(protocol_err), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rdy_after_rst", 64'(data_in_ready), 64'd1);

    // Single-flit packets from (2,2), each routed fresh
    data_out_ready = 1'b1;
    push(mk(1, 1, 5, 1, 50'h1), goEast, 1);
    push(mk(1, 1, 2, 2, 50'h2), goLocal, 1);
    push(mk(1, 1, 0, 3, 50'h3), goWest, 1);
    push(mk(1, 1, 2, 4, 50'h4), goSouth, 1);
    drain();

    // Four-flit packet from (3,3); bodies carry misleading dst bits
    position.x = 3'd3;
    position.y = 3'd3;
    push(mk(1, 0, 3, 0, 50'h10), goNorth, 1);
    push(mk(0, 0, 7, 7, 50'h11), goNorth, 1);
    push(mk(0, 0, 7, 7, 50'h12), goNorth, 1);
    push(mk(0, 1, 7, 7, 50'h13), goNorth, 1);
    push(mk(1, 1, 3, 5, 50'h14), goSouth, 1);
    drain();

    // Stray head inside an open packet keeps the latched route
    push(mk(1, 0, 0, 3, 50'h20), goWest, 1);
    push(mk(1, 0, 7, 3, 50'h21), goWest, 1);
    push(mk(0, 1, 7, 3, 50'h22), goWest, 1);
    push(mk(1, 1, 3, 3, 50'h23), goLocal, 1);
    drain();

    // Fill with output stalled: fifth flit held until space frees
    data_out_ready = 1'b0;
    push(mk(1, 0, 3, 3, 50'h30), goLocal, 1);
    push(mk(0, 0, 0, 0, 50'h31), goLocal, 1);
    push(mk(0, 0, 0, 0, 50'h32), goLocal, 1);
    push(mk(0, 0, 0, 0, 50'h33), goLocal, 1);
    @(negedge clk);
    chk("full_rdy", 64'(data_in_ready), 64'd0);
    chk("full_valid", 64'(data_out_valid), 64'd1);
    fork
      push(mk(0, 1, 0, 0, 50'h34), goLocal, 1);
      begin
        repeat (3) @(negedge clk);
        chk("held_rdy", 64'(data_in_ready), 64'd0);
        @(posedge clk);
        #1;
        data_out_ready = 1'b1;
      end
    join
    drain();

    // Orphan body flit is dropped and flags a sticky error
    push(mk(0, 0, 5, 5, 50'h40), goNone, 0);
    @(negedge clk);
    chk("drop_valid", 64'(data_out_valid), 64'd0);
    @(negedge clk);
    chk("err_set", 64'(protocol_err), 64'd1);
    push(mk(1, 1, 1, 3, 50'h41), goWest, 1);
    drain();
    chk("err_sticky", 64'(protocol_err), 64'd1);
    pulse_rst();
    @(negedge clk);
    chk("err_cleared", 64'(protocol_err), 64'd0);

    // Reset in the middle of a packet forgets flits and route
    data_out_ready = 1'b0;
    push(mk(1, 0, 5, 3, 50'h50), goEast, 1);
    push(mk(0, 0, 5, 3, 50'h51), goEast, 1);
    pulse_rst();
    @(negedge clk);
    chk("mid_rst_valid", 64'(data_out_valid), 64'd0);
    chk("mid_rst_route", 64'(route_out), 64'd0);
    data_out_ready = 1'b1;
    push(mk(1, 1, 1, 3, 50'h52), goWest, 1);
    drain();

`ifdef NOC_INPUT_BYPASS_EN
    begin
      exp_t e;
      position.x = 3'd2;
      position.y = 3'd2;
      e.d = mk(1, 1, 2, 2, 50'h60);
      e.r = goLocal;
      sb.push_back(e);
      @(posedge clk);
      #1;
      data_in = e.d;
      data_in_valid = 1'b1;
      @(negedge clk);
      chk("byp_valid", 64'(data_out_valid), 64'd1);
      chk("byp_route", 64'(route_out), 64'(goLocal));
      @(posedge clk);
      #1;
      data_in_valid = 1'b0;
      drain();
    end
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
